// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and control bundle for the decode queue
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_AP4  = 5'd11;
    localparam logic [4:0] ALU_BOUT = 5'd12;
    localparam logic [4:0] ALU_MUL  = 5'd13;

    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;
    localparam logic [2:0] IMM_U = 3'd5;

    localparam logic [2:0] CMP_EQ  = 3'd1;
    localparam logic [2:0] CMP_NE  = 3'd2;
    localparam logic [2:0] CMP_LT  = 3'd3;
    localparam logic [2:0] CMP_LTU = 3'd4;
    localparam logic [2:0] CMP_GE  = 3'd5;
    localparam logic [2:0] CMP_GEU = 3'd6;

    localparam logic [1:0] HZ_NONE  = 2'd0;
    localparam logic [1:0] HZ_ALU   = 2'd1;
    localparam logic [1:0] HZ_LOAD  = 2'd2;
    localparam logic [1:0] HZ_STORE = 2'd3;

    localparam logic [31:0] INST_ECALL  = 32'h00000073;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_MRET   = 32'h30200073;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic [2:0] imm_sel;
        logic [2:0] cmp_ctrl;
        logic       alusrc_a;
        logic       alusrc_b;
        logic       data_to_reg;
        logic       reg_write;
        logic       mem_w;
        logic       mem_r;
        logic       rs1use;
        logic       rs2use;
        logic       jal;
        logic       jalr;
        logic       bop;
        logic       mret;
        logic       csr_rw;
        logic       csr_imm;
        logic [1:0] hazard_optype;
        logic [2:0] exp_vector;
    } ctrl_bundle_t;

    // Base-ISA funct3 to ALU op for the register and immediate arithmetic groups
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_from_f3 = ALU_ADD;
            3'd1:    alu_from_f3 = ALU_SLL;
            3'd2:    alu_from_f3 = ALU_SLT;
            3'd3:    alu_from_f3 = ALU_SLTU;
            3'd4:    alu_from_f3 = ALU_XOR;
            3'd5:    alu_from_f3 = ALU_SRL;
            3'd6:    alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_core.sv
// rtl/ctrl_decode_core.sv - combinational RV32I+Zicsr decode, optional M ops under RV32M_EN
module ctrl_decode_core
    import ctrl_pkg::*;
(
    input  logic [31:0]  inst,
    output ctrl_bundle_t ctrl
);

    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic         ill;
    ctrl_bundle_t c;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    // Decode by opcode class, then squash side effects of anything illegal
    always_comb begin
        c   = '0;
        ill = 1'b0;
        case (opc)
            OPC_OP: begin
                c.rs1use        = 1'b1;
                c.rs2use        = 1'b1;
                c.reg_write     = 1'b1;
                c.hazard_optype = HZ_ALU;
                if (f7 == 7'h00) begin
                    c.alu_ctrl = alu_from_f3(f3);
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    c.alu_ctrl = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    c.alu_ctrl = ALU_SRA;
`ifdef RV32M_EN
                end else if (f7 == 7'h01) begin
                    c.alu_ctrl = ALU_MUL + {2'b00, f3};
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                c.imm_sel       = IMM_I;
                c.alusrc_b      = 1'b1;
                c.rs1use        = 1'b1;
                c.reg_write     = 1'b1;
                c.hazard_optype = HZ_ALU;
                c.alu_ctrl      = alu_from_f3(f3);
                if (f3 == 3'd1 && f7 != 7'h00) begin
                    ill = 1'b1;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h20) begin
                        c.alu_ctrl = ALU_SRA;
                    end else if (f7 != 7'h00) begin
                        ill = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                c.alu_ctrl      = ALU_ADD;
                c.imm_sel       = IMM_I;
                c.alusrc_b      = 1'b1;
                c.mem_r         = 1'b1;
                c.data_to_reg   = 1'b1;
                c.reg_write     = 1'b1;
                c.rs1use        = 1'b1;
                c.hazard_optype = HZ_LOAD;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                c.alu_ctrl      = ALU_ADD;
                c.imm_sel       = IMM_S;
                c.alusrc_b      = 1'b1;
                c.mem_w         = 1'b1;
                c.rs1use        = 1'b1;
                c.rs2use        = 1'b1;
                c.hazard_optype = HZ_STORE;
                ill = (f3 > 3'd2);
            end
            OPC_BRANCH: begin
                // ALU forms the target (pc + imm); the compare happens downstream
                c.alu_ctrl = ALU_ADD;
                c.imm_sel  = IMM_B;
                c.alusrc_a = 1'b1;
                c.alusrc_b = 1'b1;
                c.bop      = 1'b1;
                c.rs1use   = 1'b1;
                c.rs2use   = 1'b1;
                case (f3)
                    3'd0:    c.cmp_ctrl = CMP_EQ;
                    3'd1:    c.cmp_ctrl = CMP_NE;
                    3'd4:    c.cmp_ctrl = CMP_LT;
                    3'd5:    c.cmp_ctrl = CMP_GE;
                    3'd6:    c.cmp_ctrl = CMP_LTU;
                    3'd7:    c.cmp_ctrl = CMP_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                c.alu_ctrl      = ALU_AP4;
                c.imm_sel       = IMM_J;
                c.alusrc_a      = 1'b1;
                c.jal           = 1'b1;
                c.reg_write     = 1'b1;
                c.hazard_optype = HZ_ALU;
            end
            OPC_JALR: begin
                c.alu_ctrl      = ALU_AP4;
                c.imm_sel       = IMM_I;
                c.alusrc_a      = 1'b1;
                c.jalr          = 1'b1;
                c.reg_write     = 1'b1;
                c.rs1use        = 1'b1;
                c.hazard_optype = HZ_ALU;
                ill = (f3 != 3'd0);
            end
            OPC_LUI: begin
                c.alu_ctrl      = ALU_BOUT;
                c.imm_sel       = IMM_U;
                c.alusrc_b      = 1'b1;
                c.reg_write     = 1'b1;
                c.hazard_optype = HZ_ALU;
            end
            OPC_AUIPC: begin
                c.alu_ctrl      = ALU_ADD;
                c.imm_sel       = IMM_U;
                c.alusrc_a      = 1'b1;
                c.alusrc_b      = 1'b1;
                c.reg_write     = 1'b1;
                c.hazard_optype = HZ_ALU;
            end
            OPC_FENCE: begin
                ill = 1'b0;
            end
            OPC_SYSTEM: begin
                if (f3 == 3'd0) begin
                    if (inst == INST_ECALL) begin
                        c.exp_vector[0] = 1'b1;
                    end else if (inst == INST_EBREAK) begin
                        c.exp_vector[2] = 1'b1;
                    end else if (inst == INST_MRET) begin
                        c.mret = 1'b1;
                    end else begin
                        ill = 1'b1;
                    end
                end else if (f3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    // CSR read data returns on the load path
                    c.csr_rw        = 1'b1;
                    c.csr_imm       = f3[2];
                    c.rs1use        = ~f3[2];
                    c.reg_write     = 1'b1;
                    c.data_to_reg   = 1'b1;
                    c.hazard_optype = HZ_LOAD;
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            c.reg_write     = 1'b0;
            c.mem_w         = 1'b0;
            c.mem_r         = 1'b0;
            c.csr_rw        = 1'b0;
            c.jal           = 1'b0;
            c.jalr          = 1'b0;
            c.bop           = 1'b0;
            c.exp_vector[1] = 1'b1;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/ctrl_decode_queue.sv
// rtl/ctrl_decode_queue.sv - decode-on-enqueue control FIFO with flush (M ops via RV32M_EN)
module ctrl_decode_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [4:0]               out_alu_ctrl,
    output logic [2:0]               out_imm_sel,
    output logic [2:0]               out_cmp_ctrl,
    output logic                     out_alusrc_a,
    output logic                     out_alusrc_b,
    output logic                     out_data_to_reg,
    output logic                     out_reg_write,
    output logic                     out_mem_w,
    output logic                     out_mem_r,
    output logic                     out_rs1use,
    output logic                     out_rs2use,
    output logic                     out_jal,
    output logic                     out_jalr,
    output logic                     out_bop,
    output logic                     out_mret,
    output logic                     out_csr_rw,
    output logic                     out_csr_imm,
    output logic [1:0]               out_hazard_optype,
    output logic [2:0]               out_exp_vector,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    ctrl_bundle_t    dec;
    ctrl_bundle_t    bnd_mem [DEPTH];
    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic [31:0]     inst_mem[DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    ctrl_bundle_t    hd;

    ctrl_decode_core u_core (
        .inst (in_inst),
        .ctrl (dec)
    );

    assign in_ready  = (count < FULL) & ~flush;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry storage; stale slots are never visible because the head is gated by count
    always_ff @(posedge clk) begin
        if (push) begin
            bnd_mem[wr_ptr]  <= dec;
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Pointer and occupancy tracking; flush takes priority over any pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign hd       = out_valid ? bnd_mem[rd_ptr]  : '0;
    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;

    assign out_alu_ctrl      = hd.alu_ctrl;
    assign out_imm_sel       = hd.imm_sel;
    assign out_cmp_ctrl      = hd.cmp_ctrl;
    assign out_alusrc_a      = hd.alusrc_a;
    assign out_alusrc_b      = hd.alusrc_b;
    assign out_data_to_reg   = hd.data_to_reg;
    assign out_reg_write     = hd.reg_write;
    assign out_mem_w         = hd.mem_w;
    assign out_mem_r         = hd.mem_r;
    assign out_rs1use        = hd.rs1use;
    assign out_rs2use        = hd.rs2use;
    assign out_jal           = hd.jal;
    assign out_jalr          = hd.jalr;
    assign out_bop           = hd.bop;
    assign out_mret          = hd.mret;
    assign out_csr_rw        = hd.csr_rw;
    assign out_csr_imm       = hd.csr_imm;
    assign out_hazard_optype = hd.hazard_optype;
    assign out_exp_vector    = hd.exp_vector;

endmodule
